km_pipe: RTL and testbench
==========================

Name: km_pipe

Overview:
- Parametrised, fully pipelined Karatsuba multiplier with valid/ready flow control.
- Successor to the fixed-width combinational-style km multiplier used by the NTT butterfly units.
- Accepts one WIDTH x WIDTH operand pair per cycle and returns the 2*WIDTH-bit product split into high and low words.
- Optional Barrett stage also returns the product mod P for direct use in the butterfly datapath.

Parameters:
- WIDTH, 32: operand width. Must be even, range 8..64. H = WIDTH/2.
- P, 343576577: modulus, used only with KM_MODRED_EN. Requires P < 2^K.
- K, 29: bit length of P. Requires K <= WIDTH.
- MU is a localparam, not an override: floor(2^(2K)/P), computed at elaboration in 64-bit or wider arithmetic.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready.
- in1  in  WIDTH  multiplicand.
- in2  in  WIDTH  multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- out_L  out  WIDTH  low word of in1*in2.
- out_H  out  WIDTH  high word of in1*in2.
- out_mod  out  WIDTH  (in1*in2) mod P; driven 0 when KM_MODRED_EN is undefined.

Behaviour:
- Reset: rstn low clears all stage valid bits immediately (async). out_valid=0, out_L=0, out_H=0, out_mod=0. in_ready=1 from the first clock after release.
- Global enable: en = !out_valid || out_ready. in_ready = en, combinational. All stage registers load only when en=1. A stall freezes every stage, with no bubbles dropped and no duplicates.
- S1: register a1=in1[W-1:H], a0, b1, b0; sa=a1+a0 and sb=b1+b0, each H+1 bits. v1 <= in_valid && in_ready.
- S2: register z2=a1*b1 (2H bits), z0=a0*b0 (2H bits), zm=sa*sb (2H+2 bits). v2 <= v1.
- S3: z1=zm-z2-z0, always non-negative, fits 2H+1 bits. prod = (z2<<WIDTH) + (z1<<H) + z0, truncated to 2*WIDTH bits (exact). out_H=prod[2W-1:W], out_L=prod[W-1:0]. out_valid <= v2.
- Latency: 3 cycles from accepted input to out_valid when no stall. Throughput is 1 per cycle.
- Backpressure: out_ready=0 while out_valid=1 holds all outputs stable and in_ready=0. Inputs presented while in_ready=0 are not captured.
- When a stage is empty (valid=0), its data registers may update but the valid must stay 0. Outputs are meaningful only while out_valid=1.
- Simultaneous accept and emit in the same cycle is legal at full rate.
- rstn asserted mid-operation discards all in-flight results. No result emerges after reset release without a new accepted input.
- Operands are unsigned full range. 0 and 2^WIDTH-1 are legal with no overflow.

Optional Feature:
- Macro: KM_MODRED_EN.
- Defined: two further stages S4 and S5 are appended, giving 5-cycle latency; out_H and out_L are delayed to stay aligned.
  - S4: q = ((prod >> (K-1)) * MU) >> (K+1).
  - S5: r = prod - q*P, then up to two conditional subtractions of P. out_mod = r, always < P.
  - Requires in1, in2 < P; behaviour is undefined otherwise. Stall, reset and backpressure rules apply unchanged to S4 and S5.
- Undefined: latency is 3 and out_mod is constant 0.

Test Plan:
- Reset: hold rstn=0 for 5 cycles with in_valid=1 -> out_valid=0 and all outputs 0 throughout. in_ready=1 after release.
- Basic: in1=3, in2=5, out_ready=1 -> exactly 3 cycles later out_valid=1, out_H=0, out_L=15 (5 cycles and out_mod=15 with KM_MODRED_EN).
- Extremes (WIDTH=32): in1=in2=0xFFFFFFFF -> out_H=0xFFFFFFFE, out_L=0x00000001. Then in1=in2=0x00010000 -> out_H=1, out_L=0. Also 1000 random pairs checked against in1*in2.
- Backpressure: stream 8 consecutive pairs (i, i+1) with out_ready toggled every other cycle -> 8 results in order, each held stable while stalled, none lost or duplicated, in_ready=0 exactly while stalled.
- Reset mid-stream: assert rstn with 3 results in flight -> out_valid drops immediately and nothing appears after release until a new input is accepted.
- KM_MODRED_EN: in1=in2=P-1 -> out_mod=1. in1=in2=65536 -> out_mod=172048372. 1000 random pairs below P checked against (in1*in2)%P.

Source files
------------

// File: rtl/km_pipe.sv
// km_pipe: pipelined Karatsuba multiplier (WIDTH x WIDTH -> 2*WIDTH) with valid/ready flow control.
// Define KM_MODRED_EN to append a two-stage Barrett reduction that drives out_mod = product mod P.
module km_pipe #(
  parameter int          WIDTH = 32,
  parameter logic [63:0] P     = 64'd343576577,
  parameter int          K     = 29
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_L,
  output logic [WIDTH-1:0] out_H,
  output logic [WIDTH-1:0] out_mod
);
  localparam int H  = WIDTH / 2;
  localparam int ZW = 2*H + 2;
  localparam int PW = 2*WIDTH;

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
      $error("km_pipe: WIDTH must be even and within 8..64");
    end
    if (K < 2 || K > WIDTH || (P >> K) != 64'd0) begin : g_bad_mod
      $error("km_pipe: need 2 <= K <= WIDTH and P < 2**K");
    end
  endgenerate

  // One enable for the whole pipe: a stall freezes every stage together.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic [H-1:0]   a1_reg, a0_reg, b1_reg, b0_reg;
  logic [H:0]     sa_reg, sb_reg;
  logic [2*H-1:0] z2_reg, z0_reg;
  logic [ZW-1:0]  zm_reg;
  logic [PW-1:0]  prod_reg;
  logic           v1_reg, v2_reg, v3_reg;

  logic [ZW-1:0]  z1_next;
  logic [PW-1:0]  prod_next;

  // zm - z2 - z0 is the cross term a1*b0 + a0*b1, never negative.
  always_comb begin
    z1_next   = zm_reg - ZW'(z2_reg) - ZW'(z0_reg);
    prod_next = {z2_reg, z0_reg} + (PW'(z1_next) << H);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_reg   <= 1'b0;
      v2_reg   <= 1'b0;
      v3_reg   <= 1'b0;
      a1_reg   <= '0;
      a0_reg   <= '0;
      b1_reg   <= '0;
      b0_reg   <= '0;
      sa_reg   <= '0;
      sb_reg   <= '0;
      z2_reg   <= '0;
      z0_reg   <= '0;
      zm_reg   <= '0;
      prod_reg <= '0;
    end else if (en) begin
      v1_reg   <= in_valid;
      a1_reg   <= in1[WIDTH-1:H];
      a0_reg   <= in1[H-1:0];
      b1_reg   <= in2[WIDTH-1:H];
      b0_reg   <= in2[H-1:0];
      sa_reg   <= {1'b0, in1[WIDTH-1:H]} + {1'b0, in1[H-1:0]};
      sb_reg   <= {1'b0, in2[WIDTH-1:H]} + {1'b0, in2[H-1:0]};

      v2_reg   <= v1_reg;
      z2_reg   <= (2*H)'(a1_reg) * (2*H)'(b1_reg);
      z0_reg   <= (2*H)'(a0_reg) * (2*H)'(b0_reg);
      zm_reg   <= ZW'(sa_reg) * ZW'(sb_reg);

      v3_reg   <= v2_reg;
      prod_reg <= prod_next;
    end
  end

`ifdef KM_MODRED_EN
  localparam int MUW = 2*K + 2;
  localparam int QW  = PW + MUW;
  localparam logic [MUW-1:0] MU = (MUW'(1) << (2*K)) / MUW'(P);

  logic [PW-1:0]    q_next, q_reg, prod4_reg, prod5_reg;
  logic [PW-1:0]    r0, r1, r2;
  logic [WIDTH-1:0] mod_reg;
  logic             v4_reg, v5_reg;

  // Barrett estimate undershoots the true quotient by at most 2, hence two corrections.
  always_comb begin
    q_next = PW'((QW'(prod_reg >> (K-1)) * QW'(MU)) >> (K+1));
    r0     = prod4_reg - q_reg * PW'(P);
    r1     = (r0 >= PW'(P)) ? r0 - PW'(P) : r0;
    r2     = (r1 >= PW'(P)) ? r1 - PW'(P) : r1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v4_reg    <= 1'b0;
      v5_reg    <= 1'b0;
      q_reg     <= '0;
      prod4_reg <= '0;
      prod5_reg <= '0;
      mod_reg   <= '0;
    end else if (en) begin
      v4_reg    <= v3_reg;
      q_reg     <= q_next;
      prod4_reg <= prod_reg;
      v5_reg    <= v4_reg;
      prod5_reg <= prod4_reg;
      mod_reg   <= WIDTH'(r2);
    end
  end

  assign out_valid = v5_reg;
  assign out_H     = prod5_reg[PW-1:WIDTH];
  assign out_L     = prod5_reg[WIDTH-1:0];
  assign out_mod   = mod_reg;
`else
  assign out_valid = v3_reg;
  assign out_H     = prod_reg[PW-1:WIDTH];
  assign out_L     = prod_reg[WIDTH-1:0];
  assign out_mod   = '0;
`endif

endmodule

// File: tb/tb_km_pipe.sv
// tb_km_pipe: directed vector table plus streaming, backpressure and reset sequences for km_pipe.
module tb_km_pipe;
  localparam int W = 32;
  localparam logic [63:0] P_MOD = 64'd343576577;
`ifdef KM_MODRED_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_L, out_H, out_mod;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [63:0]  exp_prod_q[$];
  logic [W-1:0] exp_mod_q[$];

  typedef struct {
    string        nm;
    logic [W-1:0] a, b, eh, el, em;
  } vec_t;
  vec_t vecs[7];

  km_pipe #(.WIDTH(W), .P(P_MOD), .K(29)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_L(out_L), .out_H(out_H), .out_mod(out_mod)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [W-1:0] ref_mod(input logic [63:0] p);
`ifdef KM_MODRED_EN
    return W'(p % P_MOD);
`else
    return (p == 64'd0) ? '0 : '0;
`endif
  endfunction

  function automatic logic [W-1:0] rand_operand();
`ifdef KM_MODRED_EN
    return W'($urandom_range(32'(P_MOD) - 1));
`else
    return W'($urandom);
`endif
  endfunction

  // Single transfer with idle pipe: checks exact latency, then the result words.
  task automatic send_one(input string nm, input logic [W-1:0] a, b, eh, el, em);
    @(negedge clk);
    in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check({nm, "_latency"}, 64'(out_valid), 64'(k == LAT));
    end
    check({nm, "_H"}, 64'(out_H), 64'(eh));
    check({nm, "_L"}, 64'(out_L), 64'(el));
    check({nm, "_mod"}, 64'(out_mod), 64'(em));
    $display("vec %-8s in1=0x%08h in2=0x%08h -> H=0x%08h L=0x%08h mod=%0d", nm, a, b, out_H, out_L, out_mod);
  endtask

  // Stream n operand pairs; rnd=0 sends (i, i+1) with out_ready toggling, rnd=1 randomises everything.
  task automatic run_stream(input string nm, input int n, input bit rnd);
    int sent = 0, got = 0, cyc = 0;
    bit stalled_prev = 1'b0;
    logic [W-1:0] hold_h = '0, hold_l = '0, hold_m = '0;
    logic [63:0] p;
    exp_prod_q.delete();
    exp_mod_q.delete();
    while (got < n && cyc < 20000) begin
      @(negedge clk);
      if (sent < n) begin
        in_valid = rnd ? 1'($urandom_range(1)) : 1'b1;
        in1 = rnd ? rand_operand() : W'(sent);
        in2 = rnd ? rand_operand() : W'(sent + 1);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = rnd ? 1'($urandom_range(1)) : 1'(cyc % 2);
      #1;
      if (stalled_prev) begin
        check({nm, "_hold_valid"}, 64'(out_valid), 64'd1);
        check({nm, "_hold_H"}, 64'(out_H), 64'(hold_h));
        check({nm, "_hold_L"}, 64'(out_L), 64'(hold_l));
        check({nm, "_hold_mod"}, 64'(out_mod), 64'(hold_m));
      end
      check({nm, "_in_ready"}, 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_prod_q.size() == 0) begin
          check({nm, "_spurious"}, 64'd1, 64'd0);
        end else begin
          p = exp_prod_q.pop_front();
          check({nm, "_H"}, 64'(out_H), 64'(p[63:32]));
          check({nm, "_L"}, 64'(out_L), 64'(p[31:0]));
          check({nm, "_mod"}, 64'(out_mod), 64'(exp_mod_q.pop_front()));
          $display("%s #%0d H=0x%08h L=0x%08h mod=%0d", nm, got, out_H, out_L, out_mod);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        p = 64'(in1) * 64'(in2);
        exp_prod_q.push_back(p);
        exp_mod_q.push_back(ref_mod(p));
        sent++;
      end
      stalled_prev = out_valid && !out_ready;
      hold_h = out_H; hold_l = out_L; hold_m = out_mod;
      cyc++;
    end
    check({nm, "_count"}, 64'(got), 64'(n));
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      check({nm, "_no_dup"}, 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
`ifdef KM_MODRED_EN
    vecs[0] = '{"small",   32'd3,        32'd5,        32'h0,        32'd15,        32'd15};
    vecs[1] = '{"pm1_sq",  32'h147A9000, 32'h147A9000, 32'h01A3612D, 32'h91000000, 32'd1};
    vecs[2] = '{"half_sq", 32'h00010000, 32'h00010000, 32'h1,        32'h0,         32'd172048372};
    vecs[3] = '{"zero",    32'h0,        32'h147A9000, 32'h0,        32'h0,         32'd0};
    vecs[4] = '{"one_pm1", 32'h1,        32'h147A9000, 32'h0,        32'h147A9000,  32'd343576576};
    vecs[5] = '{"two_pm1", 32'h2,        32'h147A9000, 32'h0,        32'h28F52000,  32'd343576575};
    vecs[6] = '{"lo_hi",   32'h00010000, 32'h0000FFFF, 32'h0,        32'hFFFF0000,  32'd171982836};
`else
    vecs[0] = '{"small",   32'd3,        32'd5,        32'h0,        32'd15,        32'd0};
    vecs[1] = '{"max_sq",  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001,  32'd0};
    vecs[2] = '{"half_sq", 32'h00010000, 32'h00010000, 32'h1,        32'h0,         32'd0};
    vecs[3] = '{"zero",    32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,         32'd0};
    vecs[4] = '{"one_max", 32'h1,        32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF,  32'd0};
    vecs[5] = '{"max_x2",  32'hFFFFFFFF, 32'h2,        32'h1,        32'hFFFFFFFE,  32'd0};
    vecs[6] = '{"lo_hi",   32'h00010000, 32'h0000FFFF, 32'h0,        32'hFFFF0000,  32'd0};
`endif

    // Reset held with in_valid high: nothing may come out.
    rstn = 1'b0; in_valid = 1'b1; in1 = 32'd3; in2 = 32'd5; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("reset_outputs", {31'd0, out_valid, out_H, out_L} | 64'(out_mod), 64'd0);
    end
    in_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_idle", 64'(out_valid), 64'd0);

    foreach (vecs[i]) send_one(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].em);

    run_stream("bp", 8, 1'b0);
    run_stream("rnd", 1000, 1'b1);

    // Reset with three results in flight: they must all vanish.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in1 = 32'd7; in2 = 32'd9;
    @(negedge clk); in1 = 32'd8;
    @(negedge clk); in1 = 32'd10;
    @(negedge clk); in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("midrst_async_valid", 64'(out_valid), 64'd0);
    check("midrst_async_H", 64'(out_H), 64'd0);
    check("midrst_async_L", 64'(out_L), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 2*LAT + 2; k++) begin
      @(negedge clk);
      check("midrst_quiet", 64'(out_valid), 64'd0);
    end
    send_one("post_rst", 32'd6, 32'd7, 32'd0, 32'd42, ref_mod(64'd42));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end
endmodule
